ws2812_bus_ctrl: RTL and testbench

WS2812_BUS_CTRL -- requirements
Module: ws2812_bus_ctrl

---
 rtl/ws2812_pkg.sv | 27 ++
 rtl/ws2812_cmd_fifo.sv | 67 ++++++
 rtl/ws2812_bus_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ws2812_bus_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - register offsets, drain FSM encoding, FIFO sizing and channel scaling
package ws2812_pkg;

    localparam logic [31:0] REG_CTRL     = 32'h0000_0000;
    localparam logic [31:0] REG_BRIGHT   = 32'h0000_0004;
    localparam logic [31:0] REG_STATUS   = 32'h0000_0008;
    localparam logic [23:0] LED_PAGE     = 24'h00_0001;

    localparam int FIFO_DEPTH   = 4;
    localparam int FIFO_WIDTH   = 8 + 24;
    localparam int SHADOW_SLOTS = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCALE   = 2'd1,
        ST_WRITE   = 2'd2,
        ST_REFRESH = 2'd3
    } state_e;

    // Full brightness (0xFF) multiplies by 256, so the channel passes through unchanged.
    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] br);
        logic [15:0] prod;
        prod = {8'd0, ch} * ({8'd0, br} + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws2812_cmd_fifo.sv
// rtl/ws2812_cmd_fifo.sv - 4-entry {led, rgb} command FIFO with first-word fall-through and flush
module ws2812_cmd_fifo
    import ws2812_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [FIFO_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [FIFO_WIDTH-1:0] pop_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [2:0]            level_o
);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [2:0]            level_q, level_d;
    logic                  do_push, do_pop;

    assign full_o     = (level_q == 3'(FIFO_DEPTH));
    assign empty_o    = (level_q == 3'd0);
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A pop frees its slot in the same cycle, so a push into a full FIFO may ride along with it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            level_d  = 3'd0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 2'd1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 2'd1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 3'd1;
                2'b01:   level_d = level_q - 3'd1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            level_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ws2812_bus_ctrl.sv
// rtl/ws2812_bus_ctrl.sv - memory-mapped ws2812 chain controller: shadow, command FIFO, brightness drain FSM
// Optional LED shadow readback is built when WS2812_READBACK_EN is defined.
module ws2812_bus_ctrl
    import ws2812_pkg::*;
#(
    parameter int          NUM_LEDS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        write
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_LEDS - 1);

    logic [31:0] off;
    logic [3:0]  led_idx;
    logic        hit_ctrl, hit_bright, hit_status, hit_led;
    logic        is_wr, req, led_wr, led_push, accept, refresh_req, busy;
    logic [23:0] shadow_new;
    logic [31:0] rd_mux;

    logic        ready_q;
    logic [31:0] rdata_q;
    logic [7:0]  bright_q;
    logic [23:0] shadow_q [SHADOW_SLOTS];

    state_e      state_q;
    logic        pending_q, refreshing_q, write_q;
    logic [3:0]  idx_q, cur_idx_q;
    logic [23:0] cur_rgb_q, rgb_q;
    logic [7:0]  led_num_q;

    logic                  fifo_clear, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_rd;
    logic [2:0]            fifo_level;
    logic                  unused_bits;

    assign off        = iomem_addr - BASE_ADDR;
    assign led_idx    = off[5:2];
    assign hit_ctrl   = (off == REG_CTRL);
    assign hit_bright = (off == REG_BRIGHT);
    assign hit_status = (off == REG_STATUS);
    assign hit_led    = (off[31:8] == LED_PAGE) && (off[1:0] == 2'b00) && (off[7:2] < 6'(NUM_LEDS));

    // ready_q masks the cycle in which the master still holds valid for a completed request.
    assign is_wr  = |iomem_wstrb;
    assign req    = iomem_valid && !ready_q && (hit_ctrl || hit_bright || hit_status || hit_led);
    assign led_wr = req && hit_led && is_wr;

    assign fifo_clear  = (state_q == ST_IDLE) && pending_q;
    assign fifo_pop    = (state_q == ST_IDLE) && !pending_q && !fifo_empty;
    assign led_push    = led_wr && (!fifo_full || fifo_pop);
    assign accept      = req && (!led_wr || led_push);
    assign refresh_req = req && is_wr && (hit_bright || (hit_ctrl && iomem_wstrb[0] && iomem_wdata[0]));
    assign busy        = (state_q != ST_IDLE) || !fifo_empty || pending_q;

    assign unused_bits = ^{iomem_wdata[31:24], fifo_rd[31:28]};

    always_comb begin
        shadow_new = shadow_q[led_idx];
        for (int b = 0; b < 3; b++) begin
            if (iomem_wstrb[b]) shadow_new[8*b +: 8] = iomem_wdata[8*b +: 8];
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        if (hit_status) begin
            rd_mux = {28'd0, fifo_level, busy};
        end else if (hit_bright) begin
            rd_mux = {24'd0, bright_q};
        end
`ifdef WS2812_READBACK_EN
        else if (hit_led) begin
            rd_mux = {8'd0, shadow_q[led_idx]};
        end
`endif
    end

    ws2812_cmd_fifo u_fifo (
        .clk         (clk),
        .reset_i     (reset),
        .clear_i     (fifo_clear),
        .push_i      (led_push),
        .push_data_i ({4'd0, led_idx, shadow_new}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q  <= 1'b0;
            rdata_q  <= 32'd0;
            bright_q <= 8'hFF;
            for (int i = 0; i < SHADOW_SLOTS; i++) shadow_q[i] <= 24'd0;
        end else begin
            ready_q <= accept;
            rdata_q <= (accept && !is_wr) ? rd_mux : 32'd0;
            if (req && is_wr && hit_bright && iomem_wstrb[0]) bright_q <= iomem_wdata[7:0];
            if (led_push) shadow_q[led_idx] <= shadow_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b1;
            refreshing_q <= 1'b0;
            idx_q        <= 4'd0;
            cur_idx_q    <= 4'd0;
            cur_rgb_q    <= 24'd0;
            rgb_q        <= 24'd0;
            led_num_q    <= 8'd0;
            write_q      <= 1'b0;
        end else begin
            write_q <= 1'b0;
            if (refresh_req) pending_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        pending_q    <= refresh_req;
                        refreshing_q <= 1'b1;
                        idx_q        <= 4'd0;
                        state_q      <= ST_REFRESH;
                    end else if (!fifo_empty) begin
                        refreshing_q <= 1'b0;
                        cur_idx_q    <= fifo_rd[27:24];
                        cur_rgb_q    <= fifo_rd[23:0];
                        state_q      <= ST_SCALE;
                    end
                end
                ST_REFRESH: begin
                    cur_idx_q <= idx_q;
                    cur_rgb_q <= shadow_q[idx_q];
                    state_q   <= ST_SCALE;
                end
                // Shadow holds {R,G,B}; the driver wants {G,R,B}.
                ST_SCALE: begin
                    rgb_q     <= {scale_ch(cur_rgb_q[15:8], bright_q),
                                  scale_ch(cur_rgb_q[23:16], bright_q),
                                  scale_ch(cur_rgb_q[7:0], bright_q)};
                    led_num_q <= {4'd0, cur_idx_q};
                    state_q   <= ST_WRITE;
                end
                ST_WRITE: begin
                    write_q <= 1'b1;
                    if (refreshing_q && (idx_q < LAST_IDX)) begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= ST_REFRESH;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign rgb_data    = rgb_q;
    assign led_num     = led_num_q;
    assign write       = write_q;

endmodule

// File: tb/tb_ws2812_bus_ctrl.sv
// tb/tb_ws2812_bus_ctrl.sv - randomized directed bench for ws2812_bus_ctrl against a behavioural model
module tb_ws2812_bus_ctrl;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam int          NL   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        write;

    ws2812_bus_ctrl #(.NUM_LEDS(NL), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .rgb_data    (rgb_data),
        .led_num     (led_num),
        .write       (write)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got_q [$];
    int          got_cyc [$];
    always @(negedge clk) begin
        if (reset === 1'b0 && write === 1'b1) begin
            got_q.push_back({led_num, rgb_data});
            got_cyc.push_back(cyc);
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [23:0] shadow_m [NL];
    int          bright_m;
    logic [31:0] exp_q [$];
    int          ready_cyc;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] sc(input logic [23:0] rgb, input int br);
        int r, g, b;
        r = (int'(rgb[23:16]) * (br + 1)) / 256;
        g = (int'(rgb[15:8]) * (br + 1)) / 256;
        b = (int'(rgb[7:0]) * (br + 1)) / 256;
        return {8'(g), 8'(r), 8'(b)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        input int budget, output logic [31:0] rd, output int lat);
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        iomem_valid = 1'b1;
        lat = -1;
        rd  = 32'd0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (iomem_ready === 1'b1) begin
                rd = iomem_rdata;
                lat = n;
                ready_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
    endtask

    task automatic led_write(input int n, input logic [23:0] v, input logic [3:0] s, output int lat);
        logic [31:0] rd;
        xfer(BASE + 32'h100 + 32'(4 * n), s, {8'd0, v}, 40, rd, lat);
        for (int b = 0; b < 3; b++) if (s[b]) shadow_m[n][8*b +: 8] = v[8*b +: 8];
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] rd;
        int lat;
        logic idle;
        idle = 1'b0;
        for (int k = 0; k < 100; k++) begin
            xfer(BASE + 32'h8, 4'd0, 32'd0, 4, rd, lat);
            if (lat >= 0 && rd == 32'd0) begin
                idle = 1'b1;
                break;
            end
        end
        chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
    endtask

    task automatic expect_refresh();
        for (int i = 0; i < NL; i++) exp_q.push_back({8'(i), sc(shadow_m[i], bright_m)});
    endtask

    task automatic check_list(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] rd;
        int          lat, n, rc;
        logic [3:0]  s;
        logic [23:0] v;
        logic [23:0] old_m [NL];
        logic [23:0] new_v [5];
        logic        either;

        reset = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        iomem_addr = 32'd0;
        iomem_wdata = 32'd0;
        bright_m = 255;
        for (int i = 0; i < NL; i++) shadow_m[i] = 24'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, iomem_ready}, 32'd0);
        chk("rst_rdata", iomem_rdata, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_rgb", {8'd0, rgb_data}, 32'd0);
        chk("rst_led", {24'd0, led_num}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Blanking refresh after reset
        expect_refresh();
        wait_idle("blank");
        check_list("blank");

        // Single LED write at full brightness, with latency
        led_write(2, 24'hFF8000, 4'hF, lat);
        rc = ready_cyc;
        chk("led2_lat_ready", 32'(lat), 32'd1);
        exp_q.push_back({8'd2, 24'h80FF00});
        wait_idle("led2");
        chk("led2_latency", (got_cyc.size() > 0) ? 32'(got_cyc[0] - rc) : 32'hFFFF_FFFF, 32'd3);
        check_list("led2");

        // Random LED writes with random byte strobes
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(0, NL - 1);
            v = 24'($urandom);
            s = 4'($urandom_range(1, 15));
            led_write(n, v, s, lat);
            exp_q.push_back({8'(n), sc(shadow_m[n], bright_m)});
            wait_idle($sformatf("rnd%0d", t));
            check_list($sformatf("rnd%0d", t));
        end

        // Brightness 0x7F refreshes the chain
        led_write(0, 24'hFF0000, 4'hF, lat);
        wait_idle("led0");
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        xfer(BASE + 32'h4, 4'h1, 32'h7F, 4, rd, lat);
        bright_m = 8'h7F;
        expect_refresh();
        wait_idle("br7f");
        chk("br7f_led0", (got_q.size() > 0) ? got_q[0] : 32'hDEAD_BEEF, {8'd0, 24'h007F00});
        check_list("br7f");

        // Random brightness, readback, then CTRL refresh
        bright_m = $urandom_range(0, 255);
        xfer(BASE + 32'h4, 4'h1, 32'(bright_m), 4, rd, lat);
        xfer(BASE + 32'h8, 4'd0, 32'd0, 4, rd, lat);
        chk("status_busy", {31'd0, rd[0]}, 32'd1);
        expect_refresh();
        wait_idle("brrnd");
        check_list("brrnd");
        xfer(BASE + 32'h4, 4'd0, 32'd0, 4, rd, lat);
        chk("bright_rd", rd, 32'(bright_m));
        xfer(BASE + 32'h0, 4'hF, 32'd1, 4, rd, lat);
        expect_refresh();
        wait_idle("ctrl");
        check_list("ctrl");
        xfer(BASE + 32'h0, 4'd0, 32'd0, 4, rd, lat);
        chk("ctrl_rd", rd, 32'd0);

        // Five back-to-back LED writes while a refresh keeps the FIFO from draining
        for (int i = 0; i < NL; i++) old_m[i] = shadow_m[i];
        xfer(BASE + 32'h0, 4'h1, 32'd1, 4, rd, lat);
        for (int k = 0; k < 5; k++) begin
            new_v[k] = 24'($urandom);
            led_write(7 - k, new_v[k], 4'hF, lat);
            if (k < 4) chk($sformatf("b2b_lat%0d", k), 32'(lat), 32'd1);
            else       chk("b2b_lat4_delayed", {31'd0, (lat > 1)}, 32'd1);
        end
        wait_idle("b2b");
        chk("b2b_count", 32'(got_q.size()), 32'(NL + 5));
        for (int i = 0; i < NL && i < got_q.size(); i++) begin
            either = (got_q[i] == {8'(i), sc(old_m[i], bright_m)}) ||
                     (got_q[i] == {8'(i), sc(shadow_m[i], bright_m)});
            chk($sformatf("b2b_ref%0d", i), {31'd0, either}, 32'd1);
        end
        for (int k = 0; k < 5 && NL + k < got_q.size(); k++)
            chk($sformatf("b2b_led%0d", k), got_q[NL + k], {8'(7 - k), sc(new_v[k], bright_m)});
        got_q.delete();
        got_cyc.delete();

        // LED 3 written after the refresh has passed it
        xfer(BASE + 32'h0, 4'h1, 32'd1, 4, rd, lat);
        expect_refresh();
        either = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (got_q.size() >= 5) begin
                either = 1'b1;
                break;
            end
        end
        chk("mid_reach_idx4", {31'd0, either}, 32'd1);
        @(posedge clk);
        #1;
        v = 24'($urandom);
        led_write(3, v, 4'hF, lat);
        exp_q.push_back({8'd3, sc(v, bright_m)});
        wait_idle("mid");
        check_list("mid");

        // Readback and out-of-range addressing
        led_write(1, 24'h123456, 4'hF, lat);
        wait_idle("rb");
        got_q.delete();
        got_cyc.delete();
        xfer(BASE + 32'h104, 4'd0, 32'd0, 4, rd, lat);
`ifdef WS2812_READBACK_EN
        chk("readback_led1", rd, 32'h0012_3456);
`else
        chk("readback_led1", rd, 32'd0);
`endif
        xfer(BASE + 32'h100 + 32'(4 * NL), 4'd0, 32'd0, 6, rd, lat);
        chk("oob_read_noready", 32'(lat), 32'hFFFF_FFFF);
        xfer(BASE + 32'h100 + 32'(4 * NL), 4'hF, 32'hABCDEF, 6, rd, lat);
        chk("oob_write_noready", 32'(lat), 32'hFFFF_FFFF);
        repeat (8) @(posedge clk);
        #1;
        chk("oob_write_nopulse", 32'(got_q.size()), 32'd0);

        // Reset in the middle of a refresh
        xfer(BASE + 32'h0, 4'h1, 32'd1, 4, rd, lat);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (got_q.size() >= 2) break;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("midrst_write%0d", k), {31'd0, write}, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        bright_m = 255;
        for (int i = 0; i < NL; i++) shadow_m[i] = 24'd0;
        expect_refresh();
        wait_idle("postrst");
        check_list("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
